// File: rtl/alu_4bit_driver_if.sv
// Command, ALU and response bundle for alu_4bit_driver.
// Checker taps chk_err/err_cnt exist only when ALU_CHECK_EN is defined.
interface alu_4bit_driver_if #(
    parameter int WIDTH = 4
`ifdef ALU_CHECK_EN
    ,
    parameter int ERR_CNT_W = 8
`endif
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [1:0]       cmd_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;

    logic             busy;
`ifdef ALU_CHECK_EN
    logic                 chk_err;
    logic [ERR_CNT_W-1:0] err_cnt;
`endif

    modport master (
        input  cmd_valid,
        input  cmd_a,
        input  cmd_b,
        input  cmd_op,
        output cmd_ready,
        output alu_a,
        output alu_b,
        output alu_sel,
        input  alu_result,
        input  alu_zero,
        output rsp_valid,
        output rsp_result,
        output rsp_zero,
        input  rsp_ready,
        output busy
`ifdef ALU_CHECK_EN
        ,
        output chk_err,
        output err_cnt
`endif
    );

    modport slave (
        output cmd_valid,
        output cmd_a,
        output cmd_b,
        output cmd_op,
        input  cmd_ready,
        input  alu_a,
        input  alu_b,
        input  alu_sel,
        output alu_result,
        output alu_zero,
        input  rsp_valid,
        input  rsp_result,
        input  rsp_zero,
        output rsp_ready,
        input  busy
`ifdef ALU_CHECK_EN
        ,
        input  chk_err,
        input  err_cnt
`endif
    );
endinterface

// File: rtl/alu_4bit_driver.sv
// Initiator for a registered ALU: one command in flight, fixed-latency wait, held response.
// Define ALU_CHECK_EN to add the result checker (chk_err pulse, saturating err_cnt).
module alu_4bit_driver #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2
`ifdef ALU_CHECK_EN
    ,
    parameter int ERR_CNT_W = 8
`endif
) (
    input logic                clk,
    input logic                rst_n,
    alu_4bit_driver_if.master  drv
);
    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            res_q     <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        res_d     = res_q;
        zero_d    = zero_q;
        capture   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (drv.cmd_valid) begin
                    alu_a_d   = drv.cmd_a;
                    alu_b_d   = drv.cmd_b;
                    alu_sel_d = drv.cmd_op;
                    cnt_d     = CNT_W'(LATENCY);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // Operands stay on alu_* while the ALU pipeline fills.
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    res_d   = drv.alu_result;
                    zero_d  = drv.alu_zero;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (drv.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign drv.cmd_ready  = (state_q == S_IDLE);
    assign drv.busy       = (state_q != S_IDLE);
    assign drv.rsp_valid  = (state_q == S_RESP);
    assign drv.rsp_result = res_q;
    assign drv.rsp_zero   = zero_q;
    assign drv.alu_a      = alu_a_q;
    assign drv.alu_b      = alu_b_q;
    assign drv.alu_sel    = alu_sel_q;

`ifdef ALU_CHECK_EN
    logic [WIDTH-1:0]     exp_res;
    logic                 exp_zero;
    logic                 mismatch;
    logic                 chk_err_q, chk_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        exp_res = '0;
        unique case (alu_sel_q)
            2'b00:   exp_res = alu_a_q + alu_b_q;
            2'b01:   exp_res = alu_a_q - alu_b_q;
            2'b10:   exp_res = alu_a_q & alu_b_q;
            default: exp_res = alu_a_q | alu_b_q;
        endcase
        exp_zero = (exp_res == '0);
    end

    assign mismatch = capture &&
                      ((drv.alu_result != exp_res) ||
                       (drv.alu_zero != exp_zero));

    always_comb begin
        chk_err_d = mismatch;
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            chk_err_q <= chk_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign drv.chk_err = chk_err_q;
    assign drv.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_alu_4bit_driver.sv
// Bench for alu_4bit_driver: behavioural ALU, transaction-level model, per-cycle compare.
// Build with ALU_CHECK_EN defined to also exercise the result checker.
module tb_alu_4bit_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bad = 1'b0;
    int errors = 0;
    int checks = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    alu_4bit_driver_if bus ();

    alu_4bit_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .drv   (bus)
    );

    function automatic logic [3:0] ref_alu(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [1:0] op);
        int r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return r[3:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Two-stage registered ALU; 'bad' forces its Result to 1.
    logic [3:0] s1a, s1b, rq;
    logic [1:0] s1op;
    logic       zq;
    always @(posedge clk) begin
        if (!rst_n) begin
            s1a <= '0; s1b <= '0; s1op <= '0;
            rq  <= '0; zq <= 1'b0;
        end else begin
            s1a  <= bus.alu_a;
            s1b  <= bus.alu_b;
            s1op <= bus.alu_sel;
            rq   <= ref_alu(s1a, s1b, s1op);
            zq   <= (ref_alu(s1a, s1b, s1op) == 4'h0);
        end
    end
    assign bus.alu_result = bad ? 4'h1 : rq;
    assign bus.alu_zero   = zq;

    // Transaction model: edges counted since accept decide every output.
    int         cyc = 0;
    int         acc = 0;
    bit         infl = 0;
    bit         started = 0;
    logic [3:0] m_a = 0, m_b = 0, m_res = 0;
    logic [1:0] m_op = 0;
    bit         m_z = 0, m_bad = 0;
    int         m_err = 0;

    always @(posedge clk) begin
        int pre;
        pre = cyc;
        if (!rst_n) begin
            started = 1; infl = 0; m_err = 0;
            m_a = 0; m_b = 0; m_op = 0;
        end else if (infl) begin
            if (pre - acc == 2 && m_bad && m_err < 255) m_err++;
            if (pre - acc >= 3 && bus.rsp_ready) infl = 0;
        end else if (bus.cmd_valid) begin
            infl  = 1;
            acc   = pre + 1;
            m_a   = bus.cmd_a;
            m_b   = bus.cmd_b;
            m_op  = bus.cmd_op;
            m_z   = (ref_alu(m_a, m_b, m_op) == 4'h0);
            m_res = bad ? 4'h1 : ref_alu(m_a, m_b, m_op);
            m_bad = bad;
        end
        cyc = pre + 1;
    end

    always @(negedge clk) begin
        int k;
        if (started) begin
            k = cyc - acc;
            chk("cmd_ready", bus.cmd_ready, !infl);
            chk("busy", bus.busy, infl);
            chk("rsp_valid", bus.rsp_valid, infl && k >= 3);
            chk("alu_a", bus.alu_a, m_a);
            chk("alu_b", bus.alu_b, m_b);
            chk("alu_sel", bus.alu_sel, m_op);
            if (infl && k >= 3) begin
                chk("rsp_result", bus.rsp_result, m_res);
                chk("rsp_zero", bus.rsp_zero, m_z);
            end
`ifdef ALU_CHECK_EN
            chk("chk_err", bus.chk_err, infl && k == 3 && m_bad);
            chk("err_cnt", bus.err_cnt, m_err);
            if (bus.chk_err) pulses++;
`endif
        end
    end

    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) timeout("accept");
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a  = 4'($urandom);
        bus.cmd_b  = 4'($urandom);
        bus.cmd_op = 2'($urandom);
    endtask

    task automatic collect(input int lo, input logic [3:0] er,
                           input logic ez, input string nm,
                           output int lat);
        int n;
        n = 0;
        bus.rsp_ready = (lo == 0);
        @(negedge clk);
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        if (!bus.rsp_valid) begin
            timeout({nm, "_rsp"});
            return;
        end
        if (lo > 0) begin
            repeat (lo) @(negedge clk);
            bus.rsp_ready = 1'b1;
        end
        chk({nm, "_res"}, bus.rsp_result, er);
        chk({nm, "_zero"}, bus.rsp_zero, ez);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [3:0] a, b, r;
        logic [1:0] op;
        bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0;
        bus.cmd_op = 0; bus.rsp_ready = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        rst_n = 1'b1;

        issue(4'h7, 4'h9, 2'd0);
        collect(0, 4'h0, 1'b1, "add_7_9", lat);
        chk("latency", lat, 3);
        issue(4'h3, 4'h5, 2'd1);
        collect(0, 4'hE, 1'b0, "sub_3_5", lat);
        issue(4'h5, 4'h5, 2'd1);
        collect(1, 4'h0, 1'b1, "sub_5_5", lat);
        issue(4'hC, 4'hA, 2'd2);
        collect(0, 4'h8, 1'b0, "and_c_a", lat);
        issue(4'hC, 4'hA, 2'd3);
        collect(2, 4'hE, 1'b0, "or_c_a", lat);

        // Backpressure with a second command already waiting.
        issue(4'h1, 4'h2, 2'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_a = 4'h3; bus.cmd_b = 4'h4; bus.cmd_op = 2'd2;
        collect(5, 4'h3, 1'b0, "bp_first", lat);
        @(negedge clk);
        chk("bp_ready_after_hs", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        chk("bp_second_busy", bus.busy, 1);
        chk("bp_second_a", bus.alu_a, 4'h3);
        bus.cmd_valid = 1'b0;
        collect(0, 4'h0, 1'b1, "bp_second", lat);

        // Reset while waiting discards the command.
        issue(4'h6, 4'h1, 2'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_alu_a", bus.alu_a, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", bus.rsp_valid, 0);
        end

        for (int i = 0; i < 40; i++) begin
            a  = 4'($urandom);
            b  = 4'($urandom);
            op = 2'($urandom);
            r  = ref_alu(a, b, op);
            issue(a, b, op);
            collect($urandom_range(0, 3), r, r == 4'h0, "rand", lat);
        end

`ifdef ALU_CHECK_EN
        bad = 1'b1;
        issue(4'h2, 4'h2, 2'd0);
        collect(0, 4'h1, 1'b0, "bad_add", lat);
        bad = 1'b0;
        chk("err_cnt_after_bad", bus.err_cnt, 1);
        chk("chk_err_pulses", pulses, 1);
        issue(4'h3, 4'h4, 2'd3);
        collect(0, 4'h7, 1'b0, "clean_or", lat);
        @(negedge clk);
        chk("err_cnt_after_clean", bus.err_cnt, 1);
        chk("chk_err_pulses_clean", pulses, 1);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
